// File: rtl/key_stepper_if.sv
// -----------------------------------------------------------------------------
// key_stepper_if
//   Signal bundle between the single-step controller and its user.
//   The CPU/board side (master) drives the raw button and the run mode. It
//   receives the step strobe, the debounced key level and the strobe count.
//
//   key_n       : raw push-button, active-low, asynchronous, may bounce
//   run_en      : 1 = auto-run stepping, 0 = manual stepping from key_n
//   step        : single-cycle step strobe
//   key_pressed : debounced button level, 1 = held
//   step_count  : strobes issued since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
interface key_stepper_if;
  logic        key_n;
  logic        run_en;
  logic        step;
  logic        key_pressed;
  logic [15:0] step_count;

  modport master (
    output key_n,
    output run_en,
    input  step,
    input  key_pressed,
    input  step_count
  );

  modport slave (
    input  key_n,
    input  run_en,
    output step,
    output key_pressed,
    output step_count
  );
endinterface

// File: rtl/key_stepper.sv
// -----------------------------------------------------------------------------
// key_stepper
//   Single-step controller for a CPU on the board. A raw push-button is
//   synchronized and debounced. Each accepted press produces one step strobe
//   while in manual mode. In auto-run mode a free-running divider produces a
//   strobe every RUN_DIV cycles, and button presses only update key_pressed.
//
// Parameters
//   DB_CYCLES : stable samples needed to accept a level change on key_n
//   RUN_DIV   : clock cycles between auto-run strobes
//
// Ports
//   CLOCK_50 : system clock, all state changes on its rising edge
//   rst_n    : asynchronous, active-low reset (synchronized externally)
//   bus      : key_stepper_if.slave (key_n, run_en in; step, key_pressed,
//              step_count out). All outputs come straight from flops.
// -----------------------------------------------------------------------------
module key_stepper #(
  parameter int DB_CYCLES = 16,
  parameter int RUN_DIV   = 8
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  key_stepper_if.slave      bus
);

  // The counter only ever reaches DB_CYCLES-1, but sizing it for DB_CYCLES
  // keeps it overflow-free even for DB_CYCLES = 1.
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // Synchronizer
  logic             key_meta_q, key_meta_d;
  logic             key_sync_q, key_sync_d;

  // Debounce FSM
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             press_accept;

  // Strobe generation and outputs
  logic [DIV_W-1:0] div_q, div_d;
  logic             step_q, step_d;
  logic             key_pressed_q, key_pressed_d;
  logic [15:0]      step_count_q, step_count_d;

  logic             auto_fire;
  logic             manual_fire;

  // ---------------------------------------------------------------------------
  // Stage: two-flop synchronizer on the raw key
  // ---------------------------------------------------------------------------
  always_comb begin
    key_meta_d = bus.key_n;
    key_sync_d = key_meta_q;
  end

  // ---------------------------------------------------------------------------
  // Stage: debounce FSM, driven only by the synchronized key
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    db_cnt_d     = db_cnt_q;
    press_accept = 1'b0;

    unique case (state_q)
      RELEASED: begin
        if (!key_sync_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (key_sync_q) begin
          // Bounce or glitch: abandon the press without a strobe.
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d      = PRESSED;
          db_cnt_d     = '0;
          press_accept = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (key_sync_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end

      RELEASE_WAIT: begin
        if (!key_sync_q) begin
          // Release bounce: still held, no new press is generated.
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d  = RELEASED;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = RELEASED;
        db_cnt_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Stage: auto-run divider, strobe select and output registers
  // ---------------------------------------------------------------------------
  always_comb begin
    // Divider parks at 0 in manual mode so the first auto strobe lands
    // exactly RUN_DIV cycles after run_en rises.
    if (!bus.run_en) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    auto_fire   = bus.run_en && (div_q == DIV_LAST);
    manual_fire = press_accept && !bus.run_en;

    // run_en picks exactly one source, so a mode change can never yield
    // two strobes in one cycle.
    step_d = bus.run_en ? auto_fire : manual_fire;

    // A manual strobe right after an auto strobe (run_en just dropped)
    // would give back-to-back strobes; suppress it. Only RUN_DIV = 1 is
    // allowed to strobe every cycle.
    if ((RUN_DIV != 1) && step_q) begin
      step_d = 1'b0;
    end

    // Registered from the next state, so key_pressed lines up with the
    // cycles the FSM spends in PRESSED / RELEASE_WAIT.
    key_pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

    step_count_d  = step_count_q + 16'(step_d);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q    <= 1'b1;
      key_sync_q    <= 1'b1;
      state_q       <= RELEASED;
      db_cnt_q      <= '0;
      div_q         <= '0;
      step_q        <= 1'b0;
      key_pressed_q <= 1'b0;
      step_count_q  <= '0;
    end else begin
      key_meta_q    <= key_meta_d;
      key_sync_q    <= key_sync_d;
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      div_q         <= div_d;
      step_q        <= step_d;
      key_pressed_q <= key_pressed_d;
      step_count_q  <= step_count_d;
    end
  end

  assign bus.step        = step_q;
  assign bus.key_pressed = key_pressed_q;
  assign bus.step_count  = step_count_q;

endmodule

// File: doc/key_stepper.md
KEY_STEPPER -- requirements
Module: key_stepper

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive stable samples required to accept a level change on key_n.
REQ-002 Parameter RUN_DIV, default 8: CLOCK_50 cycles between auto-run step pulses.
REQ-003 CLOCK_50  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low; no reset synchronizer inside this block.
REQ-005 key_n  input  1  raw push-button, active-low, asynchronous to CLOCK_50, may bounce.
REQ-006 run_en  input  1  level: 1 = auto-run stepping, 0 = manual stepping from key_n.
REQ-007 step  output  1  single-cycle strobe; the CPU advances one instruction per strobe.
REQ-008 key_pressed  output  1  debounced button level, 1 = held.
REQ-009 step_count  output  16  number of step strobes issued since reset.

Function
REQ-010 The block SHALL pass key_n through a two-flop synchronizer before any other use; the synchronizer flops SHALL reset to 1 (released).
REQ-011 The debounce FSM SHALL have four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED: synchronized key = 0 -> PRESS_WAIT, clear the debounce counter.
REQ-013 PRESS_WAIT: key = 0 -> increment the counter; counter reaches DB_CYCLES-1 -> PRESSED; key = 1 at any count -> RELEASED, no strobe.
REQ-014 PRESSED: key = 1 -> RELEASE_WAIT, clear the counter.
REQ-015 RELEASE_WAIT: key = 1 -> increment the counter; counter reaches DB_CYCLES-1 -> RELEASED; key = 0 -> PRESSED.
REQ-016 key_pressed SHALL be 1 exactly in PRESSED and RELEASE_WAIT.
REQ-017 Manual strobe: in the cycle after the PRESS_WAIT->PRESSED transition, when run_en = 0, step SHALL be 1 for exactly one cycle; one strobe per accepted press, regardless of how long the button is held.
REQ-018 Auto-run: while run_en = 1, a divider SHALL count 0..RUN_DIV-1 and wrap; step SHALL be 1 for one cycle each time the divider equals RUN_DIV-1.
REQ-019 When run_en = 1, key presses SHALL be debounced and reflected on key_pressed but SHALL NOT generate strobes.
REQ-020 The divider SHALL be held at 0 while run_en = 0, so the first auto strobe comes exactly RUN_DIV cycles after run_en rises.
REQ-021 If run_en changes in the same cycle as a pending manual strobe, the block SHALL issue at most one strobe in that cycle.
REQ-022 step SHALL never be high in two consecutive cycles unless RUN_DIV = 1.
REQ-023 step_count SHALL increment on every cycle with step = 1 and wrap from 0xFFFF to 0x0000.
REQ-024 All outputs SHALL be registered; the debounce counter SHALL be wide enough for DB_CYCLES without overflow.

Reset
REQ-025 rst_n = 0 SHALL immediately force: FSM = RELEASED, counters = 0, divider = 0, step = 0, key_pressed = 0, step_count = 0.
REQ-026 Reset asserted mid-debounce or mid-press SHALL discard the pending press; after release, no strobe is issued until a new complete press.
REQ-027 When rst_n rises with key_n already held at 0, the block SHALL debounce that held press normally and issue one strobe after DB_CYCLES.

Verification
REQ-028 Clean press: DB_CYCLES = 4, run_en = 0, key_n low for 20 cycles, then high -> exactly one step strobe, 1 + 2 + 4 cycles after the falling edge (±1 cycle); step_count = 1.
REQ-029 Bounce: key_n toggles every cycle for 10 cycles, then stays high -> no strobe; key_pressed stays 0; step_count = 0.
REQ-030 Glitch shorter than the filter: key_n low for 3 cycles with DB_CYCLES = 4 -> no strobe; 10 clean presses -> step_count = 10.
REQ-031 Auto-run: RUN_DIV = 8, run_en = 1 for 80 cycles -> 10 strobes, spaced exactly 8 cycles apart; a key press during this window adds no strobe.
REQ-032 Reset mid-press: rst_n pulsed low while in PRESS_WAIT -> all outputs 0 asynchronously, no strobe after the key is released.
REQ-033 Wrap: step_count preloaded via forced auto-run to 0xFFFF, one more strobe -> step_count = 0x0000.
